aes_cipher_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 92 +++++++++
 rtl/aes_round_dp.sv | 41 ++++
 rtl/aes_sbox.sv | 39 +++
 rtl/aes_cipher_iter.sv | 168 ++++++++++++++++
 tb/tb_aes_cipher_iter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES encryption engine:
//   - block / column widths and round counts for AES-128/192/256
//   - key-length codes and the engine FSM encoding
//   - GF(2^8) helpers and the per-round linear transforms
//     (shiftrows, mixcolumns, addroundkey) plus the key-length to Nr mapping.
// State layout follows FIPS-197: byte n of the block sits at bits
// [127-8n -: 8], and column c holds bytes 4c..4c+3 (row r = byte 4c+r).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int RND_SIZE = 128;
    localparam int WRD_SIZE = 32;
    localparam int NR_128   = 10;
    localparam int NR_192   = 12;
    localparam int NR_256   = 14;

    typedef enum logic [1:0] {
        KEY_128  = 2'd0,
        KEY_192  = 2'd1,
        KEY_256  = 2'd2,
        KEY_RSVD = 2'd3
    } key_len_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Multiply by x in GF(2^8), reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Row r rotates left by r columns: out(r,c) = in(r,(c+r) mod 4).
    function automatic logic [RND_SIZE-1:0] shiftrows(input logic [RND_SIZE-1:0] s);
        logic [RND_SIZE-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [RND_SIZE-1:0] mixcolumns(input logic [RND_SIZE-1:0] s);
        logic [RND_SIZE-1:0] o;
        logic [7:0]          a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [RND_SIZE-1:0] addroundkey(input logic [RND_SIZE-1:0] s,
                                                        input logic [RND_SIZE-1:0] k);
        return s ^ k;
    endfunction

    // Reserved code falls back to AES-128 silently.
    function automatic logic [3:0] nr_of_keylen(input key_len_t kl);
        case (kl)
            KEY_192: return 4'(NR_192);
            KEY_256: return 4'(NR_256);
            default: return 4'(NR_128);
        endcase
    endfunction

endpackage

// File: rtl/aes_round_dp.sv
// -----------------------------------------------------------------------------
// aes_round_dp
// Combinational AES round datapath, split so the caller may register the
// ShiftRows result before MixColumns.
//   front half: SubBytes (NUM_BLK column S-boxes) -> ShiftRows  => sr_out
//   back half : MixColumns (skipped when final_rnd) -> AddRoundKey => rnd_out
// Ports:
//   state_in   in  RND_SIZE  state entering the round
//   mc_in      in  RND_SIZE  input to the back half (sr_out or its register)
//   rnd_key    in  RND_SIZE  round key for AddRoundKey
//   final_rnd  in  1         bypass MixColumns
//   sr_out     out RND_SIZE  SubBytes + ShiftRows result
//   rnd_out    out RND_SIZE  completed round result
// -----------------------------------------------------------------------------
module aes_round_dp #(
    parameter int RND_SIZE = 128,
    parameter int WRD_SIZE = 32,
    parameter int NUM_BLK  = 4
) (
    input  logic [RND_SIZE-1:0] state_in,
    input  logic [RND_SIZE-1:0] mc_in,
    input  logic [RND_SIZE-1:0] rnd_key,
    input  logic                final_rnd,
    output logic [RND_SIZE-1:0] sr_out,
    output logic [RND_SIZE-1:0] rnd_out
);
    import aes_pkg::*;

    logic [RND_SIZE-1:0] sub;

    for (genvar g = 0; g < NUM_BLK; g++) begin : g_sbox
        aes_sbox #(.WRD_SIZE(WRD_SIZE)) u_sbox (
            .din  (state_in[RND_SIZE-1-g*WRD_SIZE -: WRD_SIZE]),
            .dout (sub[RND_SIZE-1-g*WRD_SIZE -: WRD_SIZE])
        );
    end

    assign sr_out  = shiftrows(sub);
    assign rnd_out = addroundkey(final_rnd ? mc_in : mixcolumns(mc_in), rnd_key);

endmodule

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES S-box applied to every byte of one column.
// Each byte is inverted in GF(2^8) (x^254, 0 maps to 0) and then passed
// through the FIPS-197 affine transform.
// Ports:
//   din   in  WRD_SIZE  column before SubBytes
//   dout  out WRD_SIZE  column after SubBytes
// -----------------------------------------------------------------------------
module aes_sbox #(
    parameter int WRD_SIZE = 32
) (
    input  logic [WRD_SIZE-1:0] din,
    output logic [WRD_SIZE-1:0] dout
);
    import aes_pkg::*;

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        // Square-and-multiply: accumulates x^2 * x^4 * ... * x^128 = x^254.
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        dout = '0;
        for (int i = 0; i < WRD_SIZE/8; i++) begin
            dout[8*i +: 8] = sub_byte(din[8*i +: 8]);
        end
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// aes_cipher_iter
// Iterative AES-128/192/256 encryption engine over one shared round datapath.
// A block is accepted in IDLE (round 0 AddRoundKey applied at accept), runs
// Nr rounds in ROUND fetching round key o_key_idx from the external key store
// (combinational response on i_rnd_key), and is presented in DONE until the
// downstream handshake. PIPE=1 registers the ShiftRows result, so each round
// takes two cycles (phase 0: front half, phase 1: back half + key add).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        synchronous flush back to IDLE, pending result discarded
//   i_key_len    0/1/2 = AES-128/192/256, 3 runs as AES-128
//   i_valid      plaintext valid        o_ready   engine accepts a block (IDLE)
//   i_text       plaintext, sampled at accept only
//   o_key_idx    round-key index        i_rnd_key round key for o_key_idx
//   o_valid      ciphertext valid       i_ready   downstream accepts
//   o_cypher     ciphertext, held until next completed block
//   o_busy       high in ROUND or DONE
// -----------------------------------------------------------------------------
module aes_cipher_iter #(
    parameter int RND_SIZE = 128,
    parameter int WRD_SIZE = 32,
    parameter int CNT_SIZE = 4,
    parameter int NUM_BLK  = 4,
    parameter int PIPE     = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic [1:0]          i_key_len,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [RND_SIZE-1:0] i_text,
    output logic [CNT_SIZE-1:0] o_key_idx,
    input  logic [RND_SIZE-1:0] i_rnd_key,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [RND_SIZE-1:0] o_cypher,
    output logic                o_busy
);
    import aes_pkg::*;

    state_t              state, state_nxt;
    logic [CNT_SIZE-1:0] cnt, cnt_nxt;
    logic [CNT_SIZE-1:0] nr, nr_nxt;
    logic                phase, phase_nxt;
    logic [RND_SIZE-1:0] state_reg, state_reg_nxt;
    logic [RND_SIZE-1:0] cypher_nxt;

    logic [RND_SIZE-1:0] sr_out;
    logic [RND_SIZE-1:0] mc_in;
    logic [RND_SIZE-1:0] rnd_out;
    logic                final_rnd;
    logic                round_step;

    assign final_rnd  = (cnt == nr);
    // Without the pipeline register every ROUND cycle completes a round.
    assign round_step = (PIPE == 0) || phase;

    aes_round_dp #(
        .RND_SIZE (RND_SIZE),
        .WRD_SIZE (WRD_SIZE),
        .NUM_BLK  (NUM_BLK)
    ) u_round_dp (
        .state_in  (state_reg),
        .mc_in     (mc_in),
        .rnd_key   (i_rnd_key),
        .final_rnd (final_rnd),
        .sr_out    (sr_out),
        .rnd_out   (rnd_out)
    );

    // ---- stage boundary: SubBytes/ShiftRows -> MixColumns/AddRoundKey ----
    if (PIPE != 0) begin : g_pipe
        logic [RND_SIZE-1:0] sr_p0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr_p0 <= '0;
            end else if (state == ROUND && !phase) begin
                sr_p0 <= sr_out;
            end
        end

        assign mc_in = sr_p0;
    end else begin : g_nopipe
        assign mc_in = sr_out;
    end

    // ---- stage boundary: round result / FSM registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            nr        <= '0;
            phase     <= 1'b0;
            state_reg <= '0;
            o_cypher  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            nr        <= nr_nxt;
            phase     <= phase_nxt;
            state_reg <= state_reg_nxt;
            o_cypher  <= cypher_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        nr_nxt        = nr;
        phase_nxt     = phase;
        state_reg_nxt = state_reg;
        cypher_nxt    = o_cypher;
        o_ready       = 1'b0;
        o_valid       = 1'b0;
        o_busy        = 1'b0;
        o_key_idx     = '0;

        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    // Round 0 is folded into the accept cycle using key index 0.
                    state_reg_nxt = addroundkey(i_text, i_rnd_key);
                    nr_nxt        = CNT_SIZE'(nr_of_keylen(key_len_t'(i_key_len)));
                    cnt_nxt       = CNT_SIZE'(1);
                    phase_nxt     = 1'b0;
                    state_nxt     = ROUND;
                end
            end
            ROUND: begin
                o_busy    = 1'b1;
                o_key_idx = cnt;
                if (!round_step) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt     = 1'b0;
                    state_reg_nxt = rnd_out;
                    cnt_nxt       = cnt + 1'b1;
                    if (final_rnd) begin
                        cypher_nxt = rnd_out;
                        state_nxt  = DONE;
                    end
                end
            end
            DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Flush wins over every transition; o_cypher keeps its old value.
        if (i_clr) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            phase_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// -----------------------------------------------------------------------------
// tb_aes_cipher_iter
// Bench for aes_cipher_iter: one instance with PIPE=0 (index 0) and one with
// PIPE=1 (index 1). A behavioural AES model (byte-matrix form, S-box built by
// brute-force inversion) supplies round keys to each instance's key store and
// expected ciphertext for random blocks; FIPS-197 vectors use fixed answers.
// -----------------------------------------------------------------------------
module tb_aes_cipher_iter;

    logic         clk;
    logic         rst_n;
    logic         clr      [2];
    logic [1:0]   key_len  [2];
    logic         valid    [2];
    logic         ready    [2];
    logic [127:0] text     [2];
    logic [3:0]   kidx     [2];
    logic [127:0] rnd_key  [2];
    logic         ovalid   [2];
    logic         ready_in [2];
    logic [127:0] cypher   [2];
    logic         busy     [2];

    logic [127:0] rk [2][16];
    logic [7:0]   sbox_t [256];

    int vectors;
    int miscompares;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    assign rnd_key[0] = rk[0][kidx[0]];
    assign rnd_key[1] = rk[1][kidx[1]];

    aes_cipher_iter #(.PIPE(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (clr[0]),
        .i_key_len (key_len[0]),
        .i_valid   (valid[0]),
        .o_ready   (ready[0]),
        .i_text    (text[0]),
        .o_key_idx (kidx[0]),
        .i_rnd_key (rnd_key[0]),
        .o_valid   (ovalid[0]),
        .i_ready   (ready_in[0]),
        .o_cypher  (cypher[0]),
        .o_busy    (busy[0])
    );

    aes_cipher_iter #(.PIPE(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (clr[1]),
        .i_key_len (key_len[1]),
        .i_valid   (valid[1]),
        .o_ready   (ready[1]),
        .i_text    (text[1]),
        .o_key_idx (kidx[1]),
        .i_rnd_key (rnd_key[1]),
        .o_valid   (ovalid[1]),
        .i_ready   (ready_in[1]),
        .o_cypher  (cypher[1]),
        .o_busy    (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic int nr_of(input logic [1:0] kl);
        return (kl == 2'd1) ? 12 : (kl == 2'd2) ? 14 : 10;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic load_keys(input int d, input logic [1:0] kl, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nr = nr_of(kl);
        nk = nr - 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[d][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : {4{$urandom()}};
    endtask

    function automatic logic [127:0] model(input int d, input int nr, input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] k;
        logic [127:0] o;
        k = rk[d][0];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(r+4*c) -: 8] ^ k[127-8*(r+4*c) -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sbox_t[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < nr) begin
                    s[0][c] = gmul(8'h02, t[0][c]) ^ gmul(8'h03, t[1][c]) ^ t[2][c] ^ t[3][c];
                    s[1][c] = t[0][c] ^ gmul(8'h02, t[1][c]) ^ gmul(8'h03, t[2][c]) ^ t[3][c];
                    s[2][c] = t[0][c] ^ t[1][c] ^ gmul(8'h02, t[2][c]) ^ gmul(8'h03, t[3][c]);
                    s[3][c] = gmul(8'h03, t[0][c]) ^ t[1][c] ^ t[2][c] ^ gmul(8'h02, t[3][c]);
                end else begin
                    for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
                end
            end
            k = rk[d][rnd];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = s[r][c] ^ k[127-8*(r+4*c) -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input string what,
                       input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s: observed %h expected %h", tag, what, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int d, input logic [1:0] kl,
                         input logic [255:0] key, input logic [127:0] pt);
        load_keys(d, kl, key);
        text[d]    = pt;
        key_len[d] = kl;
        valid[d]   = 1'b1;
    endtask

    task automatic accept(input int d, input string tag);
        chk(tag, "ready_at_accept", 128'(ready[d]), 128'(1));
        tick();
        valid[d]   = 1'b0;
        text[d]    = {4{$urandom()}};
        key_len[d] = 2'($urandom_range(0, 3));
        chk(tag, "busy_after_accept", 128'(busy[d]), 128'(1));
    endtask

    task automatic finish_block(input int d, input int nr,
                                input logic [127:0] exp, input string tag);
        int waited;
        int per;
        waited = 0;
        per    = 1 + d;
        while (ovalid[d] !== 1'b1 && waited < 40) begin
            chk(tag, "key_idx", 128'(kidx[d]), 128'(1 + waited/per));
            tick();
            waited++;
        end
        chk(tag, "latency", 128'(waited), 128'(nr*per));
        chk(tag, "cypher", cypher[d], exp);
        chk(tag, "ready_in_done", 128'(ready[d]), 128'(0));
    endtask

    task automatic handshake(input int d, input string tag);
        ready_in[d] = 1'b1;
        tick();
        ready_in[d] = 1'b0;
        chk(tag, "valid_drop", 128'(ovalid[d]), 128'(0));
        chk(tag, "ready_back", 128'(ready[d]), 128'(1));
        chk(tag, "busy_drop", 128'(busy[d]), 128'(0));
    endtask

    task automatic check_reset_outputs(input int d, input string tag);
        chk(tag, "ready", 128'(ready[d]), 128'(1));
        chk(tag, "valid", 128'(ovalid[d]), 128'(0));
        chk(tag, "busy", 128'(busy[d]), 128'(0));
        chk(tag, "key_idx", 128'(kidx[d]), 128'(0));
        chk(tag, "cypher", cypher[d], 128'(0));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [127:0] last;
        logic [127:0] exp;
        logic [127:0] pt;
        logic [255:0] key;
        logic [1:0]   kl;
        int           seen;
        int           extra;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        for (int d = 0; d < 2; d++) begin
            clr[d] = 1'b0; valid[d] = 1'b0; ready_in[d] = 1'b0;
            text[d] = '0; key_len[d] = '0;
            for (int r = 0; r < 16; r++) rk[d][r] = '0;
        end
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(0, "reset0");
        check_reset_outputs(1, "reset1");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // C.1 on PIPE=0
        start(0, 2'd0, K128, PT);
        accept(0, "c1");
        finish_block(0, 10, C1, "c1");
        handshake(0, "c1");

        // C.2 on PIPE=0 (key index 1..12 checked each cycle)
        start(0, 2'd1, K192, PT);
        accept(0, "c2");
        finish_block(0, 12, C2, "c2");
        handshake(0, "c2");

        // C.3 and C.1 on PIPE=1
        start(1, 2'd2, K256, PT);
        accept(1, "c3_pipe");
        finish_block(1, 14, C3, "c3_pipe");
        handshake(1, "c3_pipe");
        start(1, 2'd0, K128, PT);
        accept(1, "c1_pipe");
        finish_block(1, 10, C1, "c1_pipe");
        handshake(1, "c1_pipe");

        // Backpressure: hold DONE 5 cycles with a new block already offered
        start(0, 2'd0, K128, PT);
        accept(0, "bp");
        finish_block(0, 10, C1, "bp");
        start(0, 2'd2, K256, PT);
        repeat (5) begin
            tick();
            chk("bp", "valid_hold", 128'(ovalid[0]), 128'(1));
            chk("bp", "cypher_hold", cypher[0], C1);
            chk("bp", "ready_low", 128'(ready[0]), 128'(0));
        end
        ready_in[0] = 1'b1;
        tick();
        ready_in[0] = 1'b0;
        chk("bp", "valid_drop", 128'(ovalid[0]), 128'(0));
        chk("bp", "not_reaccepted", 128'(busy[0]), 128'(0));
        accept(0, "bp_next");
        finish_block(0, 14, C3, "bp_next");
        handshake(0, "bp_next");

        // Flush at round 5
        last = cypher[0];
        start(0, 2'd0, K128, PT);
        accept(0, "clr");
        repeat (4) tick();
        chk("clr", "round5", 128'(kidx[0]), 128'(5));
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("clr", "ready", 128'(ready[0]), 128'(1));
        chk("clr", "busy", 128'(busy[0]), 128'(0));
        chk("clr", "key_idx", 128'(kidx[0]), 128'(0));
        chk("clr", "cypher_kept", cypher[0], last);
        seen = 0;
        repeat (15) begin
            tick();
            if (ovalid[0] !== 1'b0) seen++;
        end
        chk("clr", "valid_never", 128'(seen), 128'(0));
        start(0, 2'd0, K128, PT);
        accept(0, "clr_next");
        finish_block(0, 10, C1, "clr_next");
        handshake(0, "clr_next");

        // Asynchronous reset at round 7
        start(0, 2'd0, K128, PT);
        accept(0, "rst");
        repeat (6) tick();
        chk("rst", "round7", 128'(kidx[0]), 128'(7));
        valid[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(0, "rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst", "ready_after", 128'(ready[0]), 128'(1));
        for (int n = 0; n < 2; n++) begin
            start(0, 2'd0, K128, PT);
            accept(0, "rst_b2b");
            finish_block(0, 10, C1, "rst_b2b");
            handshake(0, "rst_b2b");
        end

        // Random blocks on both engines, including reserved key length
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 5; n++) begin
                kl  = 2'($urandom_range(0, 3));
                key = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
                pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
                start(d, kl, key, pt);
                exp = model(d, nr_of(kl), pt);
                accept(d, "rand");
                finish_block(d, nr_of(kl), exp, "rand");
                extra = $urandom_range(0, 3);
                repeat (extra) begin
                    tick();
                    chk("rand", "cypher_hold", cypher[d], exp);
                end
                handshake(d, "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
